// File: rtl/rx_comma_align_if.sv
// Bus between the serial bit source / 10b8b decoder and the comma aligner.
// The master side drives recovered bits and decoder error flags; the slave
// side (the aligner) returns framed code groups and sync status.
`timescale 1ns/1ps
interface rx_comma_align_if;
  logic       i_Bit;
  logic       i_BitVld;
  logic       i_CodeErr;
  logic       i_DispErr;
  logic [9:0] o_Word;
  logic       o_WordVld;
  logic       o_Comma;
  logic       o_Lock;
  logic [1:0] o_State;

  modport master (
    output i_Bit, i_BitVld, i_CodeErr, i_DispErr,
    input  o_Word, o_WordVld, o_Comma, o_Lock, o_State
  );

  modport slave (
    input  i_Bit, i_BitVld, i_CodeErr, i_DispErr,
    output o_Word, o_WordVld, o_Comma, o_Lock, o_State
  );
endinterface

// File: rtl/rx_comma_align.sv
// Bit-level comma aligner and sync state machine ahead of the 10b8b decoder.
// Hunts for K28.1/K28.5/K28.7, frames 10-bit code groups (first bit = bit 9),
// and uses decoder error flags to drop sync and re-hunt.
`timescale 1ns/1ps
module rx_comma_align #(
  parameter int LOCK_COMMAS = 3,
  parameter int ERR_MAX     = 4,
  parameter int GOOD_RUN    = 16
) (
  input logic            i_Clk,
  input logic            i_RstN,
  rx_comma_align_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SYNC = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_COMMAS);
  localparam logic [3:0] ERR_C  = 4'(ERR_MAX);
  localparam logic [7:0] GOOD_C = 8'(GOOD_RUN);

  state_t     state_q, state_d;
  logic [9:0] sr_q, sr_d;
  logic [3:0] ph_q, ph_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic [7:0] good_cnt_q, good_cnt_d;
  logic [9:0] word_q, word_d;
  logic       word_vld_q, word_vld_d;
  logic       comma_q, comma_d;

  logic [9:0] nsr;
  logic       comma_hit;
  logic       word_done;
  logic       word_err;
  logic [3:0] comma_inc;
  logic [3:0] err_inc;
  logic [7:0] good_inc;

  // Next-state logic: bit shifting, framing, FSM and sync/error counters.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    sr_d        = sr_q;
    ph_d        = ph_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    good_cnt_d  = good_cnt_q;
    word_d      = word_q;
    word_vld_d  = 1'b0;
    comma_d     = comma_q;

    nsr       = {sr_q[8:0], bus.i_Bit};
    comma_hit = (nsr[9:3] == 7'b0011111) || (nsr[9:3] == 7'b1100000);
    word_done = (ph_q == 4'd9);
    word_err  = word_vld_q & (bus.i_CodeErr | bus.i_DispErr);
    comma_inc = (comma_cnt_q == 4'hF) ? comma_cnt_q : comma_cnt_q + 4'd1;
    err_inc   = (err_cnt_q == 4'hF) ? err_cnt_q : err_cnt_q + 4'd1;
    good_inc  = (good_cnt_q == GOOD_C) ? good_cnt_q : good_cnt_q + 8'd1;

    // Bit-driven events: only an accepted bit moves the shifter and framer.
    if (bus.i_BitVld) begin
      sr_d = nsr;
      ph_d = word_done ? 4'd0 : ph_q + 4'd1;
      unique case (state_q)
        ST_HUNT: begin
          if (comma_hit) begin
            word_d      = nsr;
            word_vld_d  = 1'b1;
            comma_d     = 1'b1;
            ph_d        = 4'd0;
            comma_cnt_d = 4'd1;
            if (LOCK_C == 4'd1) begin
              state_d    = ST_SYNC;
              err_cnt_d  = 4'd0;
              good_cnt_d = 8'd0;
            end else begin
              state_d = ST_ACQ;
            end
          end
        end
        ST_ACQ: begin
          if (comma_hit && !word_done) begin
            // Comma off the current boundary: restart framing on it.
            word_d      = nsr;
            word_vld_d  = 1'b1;
            comma_d     = 1'b1;
            ph_d        = 4'd0;
            comma_cnt_d = 4'd1;
          end else if (word_done) begin
            word_d     = nsr;
            word_vld_d = 1'b1;
            comma_d    = comma_hit;
            if (comma_hit) begin
              comma_cnt_d = comma_inc;
              if (comma_inc >= LOCK_C) begin
                state_d    = ST_SYNC;
                err_cnt_d  = 4'd0;
                good_cnt_d = 8'd0;
              end
            end
          end
        end
        ST_SYNC: begin
          // Misaligned commas are deliberately ignored once locked.
          if (word_done) begin
            word_d     = nsr;
            word_vld_d = 1'b1;
            comma_d    = comma_hit;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    // Decoder feedback for the word currently on o_Word; an error wins over
    // any bit event on the same edge.
    if (word_vld_q) begin
      unique case (state_q)
        ST_ACQ: begin
          if (word_err) begin
            state_d     = ST_HUNT;
            comma_cnt_d = 4'd0;
          end
        end
        ST_SYNC: begin
          if (word_err) begin
            err_cnt_d  = err_inc;
            good_cnt_d = 8'd0;
            if (err_inc >= ERR_C) begin
              state_d     = ST_HUNT;
              comma_cnt_d = 4'd0;
            end
          end else if (good_inc >= GOOD_C && err_cnt_q != 4'd0) begin
            err_cnt_d  = err_cnt_q - 4'd1;
            good_cnt_d = 8'd0;
          end else begin
            good_cnt_d = good_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_Clk or negedge i_RstN) begin
    if (!i_RstN) begin
      state_q     <= ST_HUNT;
      sr_q        <= '0;
      ph_q        <= '0;
      comma_cnt_q <= '0;
      err_cnt_q   <= '0;
      good_cnt_q  <= '0;
      word_q      <= '0;
      word_vld_q  <= 1'b0;
      comma_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      sr_q        <= sr_d;
      ph_q        <= ph_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
      word_q      <= word_d;
      word_vld_q  <= word_vld_d;
      comma_q     <= comma_d;
    end
  end

  assign bus.o_Word    = word_q;
  assign bus.o_WordVld = word_vld_q;
  assign bus.o_Comma   = comma_q;
  assign bus.o_Lock    = (state_q == ST_SYNC);
  assign bus.o_State   = state_q;

endmodule

// File: tb/tb_rx_comma_align.sv
// Directed bench for rx_comma_align: reset, acquisition, realign, loss of
// sync, error forgiveness, stalled input and asynchronous reset mid-word.
`timescale 1ns/1ps
module tb_rx_comma_align;

  localparam logic [9:0] K28_5N = 10'b0011111010; // 0x0FA
  localparam logic [9:0] K28_5P = 10'b1100000101; // 0x305
  localparam logic [9:0] D21_5  = 10'b1010101010; // 0x2AA
  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_CODE = 2'b01;
  localparam logic [1:0] E_DISP = 2'b10;

  logic clk;
  logic rst_n;
  logic [1:0] err_sel;
  int cyc;
  int n_checks;
  int n_pass;

  logic [9:0] q_word[$];
  logic       q_comma[$];
  logic [1:0] q_state[$];
  logic       q_lock[$];
  int         q_cyc[$];

  rx_comma_align_if bus ();

  rx_comma_align #(
    .LOCK_COMMAS(3),
    .ERR_MAX    (4),
    .GOOD_RUN   (16)
  ) dut (
    .i_Clk (clk),
    .i_RstN(rst_n),
    .bus   (bus)
  );

  // Combinational decoder stand-in: flags errors on the word currently shown.
  assign bus.i_CodeErr = bus.o_WordVld & err_sel[0];
  assign bus.i_DispErr = bus.o_WordVld & err_sel[1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every word strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.o_WordVld === 1'b1) begin
      q_word.push_back(bus.o_Word);
      q_comma.push_back(bus.o_Comma);
      q_state.push_back(bus.o_State);
      q_lock.push_back(bus.o_Lock);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_q();
    q_word.delete();
    q_comma.delete();
    q_state.delete();
    q_lock.delete();
    q_cyc.delete();
  endtask

  task automatic chk_rec(input string tag, input int idx, input logic [9:0] w,
                         input logic c, input logic [1:0] s, input logic l);
    if (idx < q_word.size()) begin
      check($sformatf("%s[%0d].word", tag, idx), 32'(q_word[idx]), 32'(w));
      check($sformatf("%s[%0d].comma", tag, idx), 32'(q_comma[idx]), 32'(c));
      check($sformatf("%s[%0d].state", tag, idx), 32'(q_state[idx]), 32'(s));
      check($sformatf("%s[%0d].lock", tag, idx), 32'(q_lock[idx]), 32'(l));
    end else begin
      check($sformatf("%s[%0d].present", tag, idx), 32'(q_word.size()), 32'(idx + 1));
    end
  endtask

  // One bit; with stall set, i_BitVld is high on about 30% of cycles.
  task automatic send_bit(input logic b, input bit stall);
    @(negedge clk);
    if (stall) begin
      while ($urandom_range(0, 99) >= 30) begin
        bus.i_BitVld = 1'b0;
        @(negedge clk);
      end
    end
    bus.i_Bit    = b;
    bus.i_BitVld = 1'b1;
  endtask

  // Ten bits MSB first; err applies to this word's strobe.
  task automatic send_word(input logic [9:0] w, input logic [1:0] err, input bit stall);
    for (int i = 9; i >= 0; i--) begin
      send_bit(w[i], stall);
      if (i == 0) err_sel = err;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_BitVld = 1'b0;
    end
  endtask

  // Acquisition stream shared by the continuous and stalled runs.
  task automatic acq_stream(input bit stall);
    send_bit(1'b1, stall);
    send_bit(1'b0, stall);
    send_bit(1'b1, stall);
    send_word(K28_5N, E_NONE, stall);
    send_word(D21_5,  E_NONE, stall);
    send_word(K28_5P, E_NONE, stall);
    send_word(D21_5,  E_NONE, stall);
    send_word(K28_5N, E_NONE, stall);
    send_word(D21_5,  E_NONE, stall);
    idle(3);
  endtask

  task automatic acq_expect(input string tag);
    check({tag, ".count"}, 32'(q_word.size()), 32'd6);
    chk_rec(tag, 0, 10'h0FA, 1'b1, 2'd1, 1'b0);
    chk_rec(tag, 1, 10'h2AA, 1'b0, 2'd1, 1'b0);
    chk_rec(tag, 2, 10'h305, 1'b1, 2'd1, 1'b0);
    chk_rec(tag, 3, 10'h2AA, 1'b0, 2'd1, 1'b0);
    chk_rec(tag, 4, 10'h0FA, 1'b1, 2'd2, 1'b1);
    chk_rec(tag, 5, 10'h2AA, 1'b0, 2'd2, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    cyc          = 0;
    err_sel      = E_NONE;
    bus.i_Bit    = 1'b0;
    bus.i_BitVld = 1'b0;
    rst_n        = 1'b0;

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check("rst.word",  32'(bus.o_Word),    32'h000);
    check("rst.vld",   32'(bus.o_WordVld), 32'd0);
    check("rst.state", 32'(bus.o_State),   32'd0);
    check("rst.lock",  32'(bus.o_Lock),    32'd0);
    check("rst.comma", 32'(bus.o_Comma),   32'd0);
    rst_n = 1'b1;

    // Non-comma data in HUNT produces nothing.
    repeat (3) send_word(D21_5, E_NONE, 1'b0);
    idle(3);
    check("hunt.count", 32'(q_word.size()), 32'd0);
    check("hunt.state", 32'(bus.o_State),   32'd0);

    // Acquisition with continuous bits.
    clear_q();
    acq_stream(1'b0);
    acq_expect("acq");
    for (int i = 1; i < 6; i++)
      if (i < q_cyc.size())
        check($sformatf("acq.spacing%0d", i), 32'(q_cyc[i] - q_cyc[i-1]), 32'd10);

    // Loss of sync: 4 errors, never 16 good words in between.
    clear_q();
    send_word(D21_5, E_CODE, 1'b0);
    send_word(D21_5, E_NONE, 1'b0);
    send_word(D21_5, E_DISP, 1'b0);
    send_word(D21_5, E_NONE, 1'b0);
    send_word(D21_5, E_NONE, 1'b0);
    send_word(D21_5, E_CODE, 1'b0);
    send_word(D21_5, E_NONE, 1'b0);
    send_word(D21_5, E_CODE, 1'b0);
    idle(1);
    check("los.last_vld",  32'(bus.o_WordVld), 32'd1);
    check("los.last_lock", 32'(bus.o_Lock),    32'd1);
    idle(1);
    check("los.lock",  32'(bus.o_Lock),  32'd0);
    check("los.state", 32'(bus.o_State), 32'd0);
    send_word(D21_5, E_NONE, 1'b0);
    send_word(D21_5, E_NONE, 1'b0);
    idle(3);
    check("los.count", 32'(q_word.size()), 32'd8);
    chk_rec("los", 6, 10'h2AA, 1'b0, 2'd2, 1'b1);

    // Realign in ACQ: one comma, an extra bit, then a comma on the new boundary.
    clear_q();
    send_word(K28_5N, E_NONE, 1'b0);
    send_bit(1'b1, 1'b0);
    send_word(K28_5P, E_NONE, 1'b0);
    send_word(D21_5,  E_NONE, 1'b0);
    send_word(K28_5N, E_NONE, 1'b0);
    send_word(D21_5,  E_NONE, 1'b0);
    idle(3);
    check("realign.count", 32'(q_word.size()), 32'd6);
    chk_rec("realign", 0, 10'h0FA, 1'b1, 2'd1, 1'b0);
    chk_rec("realign", 1, 10'h382, 1'b0, 2'd1, 1'b0);
    chk_rec("realign", 2, 10'h305, 1'b1, 2'd1, 1'b0);
    chk_rec("realign", 3, 10'h2AA, 1'b0, 2'd1, 1'b0);
    chk_rec("realign", 4, 10'h0FA, 1'b1, 2'd1, 1'b0);
    if (q_cyc.size() >= 4) begin
      check("realign.gap",   32'(q_cyc[2] - q_cyc[1]), 32'd1);
      check("realign.frame", 32'(q_cyc[3] - q_cyc[2]), 32'd10);
    end

    // Forgiveness: third aligned comma locks, then 3 errors, 16 good, 1 error.
    clear_q();
    send_word(K28_5P, E_NONE, 1'b0);
    repeat (3)  send_word(D21_5, E_CODE, 1'b0);
    repeat (16) send_word(D21_5, E_NONE, 1'b0);
    send_word(D21_5, E_DISP, 1'b0);
    idle(3);
    check("forgive.count", 32'(q_word.size()), 32'd21);
    check("forgive.lock",  32'(bus.o_Lock),    32'd1);
    check("forgive.state", 32'(bus.o_State),   32'd2);
    send_word(D21_5, E_CODE, 1'b0);
    idle(3);
    check("forgive.drop_lock",  32'(bus.o_Lock),  32'd0);
    check("forgive.drop_state", 32'(bus.o_State), 32'd0);

    // Same acquisition stream with random stalls on i_BitVld.
    clear_q();
    acq_stream(1'b1);
    acq_expect("stall");

    // Asynchronous reset mid-word while in SYNC.
    for (int i = 9; i >= 5; i--) send_bit(D21_5[i], 1'b0);
    check("arst.pre_lock", 32'(bus.o_Lock), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.word",  32'(bus.o_Word),    32'h000);
    check("arst.vld",   32'(bus.o_WordVld), 32'd0);
    check("arst.comma", 32'(bus.o_Comma),   32'd0);
    check("arst.lock",  32'(bus.o_Lock),    32'd0);
    check("arst.state", 32'(bus.o_State),   32'd0);
    bus.i_BitVld = 1'b0;
    err_sel      = E_NONE;
    idle(2);
    rst_n = 1'b1;
    clear_q();
    send_word(D21_5, E_NONE, 1'b0);
    send_word(D21_5, E_NONE, 1'b0);
    idle(3);
    check("arst.quiet", 32'(q_word.size()), 32'd0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_word(K28_5N, E_NONE, 1'b0);
    idle(3);
    check("arst.recount", 32'(q_word.size()), 32'd1);
    chk_rec("arst", 0, 10'h0FA, 1'b1, 2'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
